lighthouse_frame_scheduler: RTL and testbench
=============================================

# lighthouse_frame_scheduler

Shares one byte-wide ESP8266 SPI master between several 256-bit lighthouse sensor-frame sources (DarkRoom instances or frame groups). Pending frame requests are arbitrated round-robin. The winning frame is snapshotted and serialized byte by byte through the SPI master's wren/wr_ack/di_req handshake. End of frame is taken from the slave-select rising edge, after which a programmable inter-frame gap is enforced. A watchdog aborts stalled transfers.

## Interface
Parameters:
- NUMBER_OF_REQUESTERS, 4, number of frame sources (2..16)
- FRAME_BYTES, 32, bytes per frame (256 bits)
- GAP_CYCLES, 1024, idle cycles after each frame; 0 means no gap
- TIMEOUT_CYCLES, 65535, watchdog limit per wait state (16-bit)

Ports (clock and reset: one clock `clock`; reset `reset_n`, asynchronous, active-low):
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req  in  N  per-requester one-cycle request pulse
- frame_data  in  N*256  frame of requester k at bits [256k+255:256k]
- grant  out  N  one-hot, one-cycle pulse when a frame is captured
- grant_id  out  4  index of the current or last granted requester
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse at end of frame, normal or aborted
- frame_error  out  1  one-cycle pulse, coincident with frame_done, on watchdog abort
- data_byte  out  8  byte to the SPI master
- wren  out  1  write request to the SPI master
- wr_ack  in  1  SPI master accepted data_byte
- di_req  in  1  SPI master ready for the next byte
- ss_n  in  1  slave select, monitored for the frame-end edge

## Operation
- Pending register, one bit per requester:
  - A req pulse sets the bit.
  - The bit clears when that requester is granted.
  - If set and clear occur in the same cycle, set wins.
  - Repeated requests while pending coalesce into one.
- States: IDLE, SEND, WAIT_REQ, WAIT_END, GAP.
- IDLE, with any pending bit set:
  - Round-robin pick, starting at grant_id+1 mod N.
  - Capture the winner's frame_data into a 256-bit buffer.
  - Pulse grant, update grant_id, clear the winner's pending bit.
  - data_byte <= buffer[7:0], wren <= 1, byte_cnt <= 0, go to SEND.
- SEND: hold wren and data_byte until wr_ack. On wr_ack:
  - wren <= 0, shift the buffer right by 8, byte_cnt++.
  - If this was byte FRAME_BYTES-1, go to WAIT_END; otherwise go to WAIT_REQ.
- WAIT_REQ: on di_req, data_byte <= buffer[7:0], wren <= 1, go to SEND.
- WAIT_END: on ss_n rising edge (registered previous value 0, current 1):
  - Pulse frame_done.
  - If GAP_CYCLES=0, go to IDLE; otherwise load the gap counter with GAP_CYCLES and go to GAP.
- GAP: decrement the counter; when it reaches 1, go to IDLE.
- Watchdog, in SEND, WAIT_REQ and WAIT_END:
  - 16-bit counter, reset on every state entry.
  - When it reaches TIMEOUT_CYCLES: wren <= 0, pulse frame_done and frame_error, go to GAP (or IDLE if GAP_CYCLES=0).
- Byte order: least significant byte first. Byte 0 is frame bits [7:0]; byte 31 is bits [255:248].
- Width rules:
  - byte_cnt is clog2(FRAME_BYTES+1) bits.
  - Gap and watchdog counters are 16 bits; they saturate and never wrap.

## Timing
- Reset values: grant=0, grant_id=N-1 (so requester 0 wins first), busy=0, frame_done=0, frame_error=0, data_byte=0, wren=0, pending=0, state=IDLE.
- Grant latency: req high in cycle t → pending set at t+1 → grant pulse and first wren at t+2. frame_data is sampled during cycle t+1.
- While IDLE, frame_data is don't-care except in the capture cycle. The source may change it during the transfer.
- wr_ack in the first SEND cycle is honoured. Each byte needs at least 2 cycles: SEND, then WAIT_REQ.
- di_req outside WAIT_REQ is ignored. wr_ack outside SEND is ignored.
- Reset mid-frame aborts immediately: all outputs return to reset values and no frame_done is issued.
- Requests arriving during a transfer or GAP are retained and served in round-robin order after the gap.

## Structure
- Package lighthouse_sched_pkg holds:
  - state encoding (3-bit)
  - FRAME_BITS=256
  - counter width constants
- Sub-module rr_arbiter: combinational round-robin arbiter, N-bit request vector plus last-grant index in, one-hot grant plus index out. Instantiated once.

## Test plan
- Single request: req[2] pulses once with frame_data[2]=0x1F…0100 (byte k = k), 1-cycle wr_ack, di_req 3 cycles later → 32 bytes 0x00..0x1F in order. grant=0100 pulses once. After the ss_n rise, frame_done pulses, then busy stays high for 1024 cycles.
- Contention: req=1111 in the same cycle → grants in order 0,1,2,3, with no overlap and exactly one frame each.
- Coalescing: req[1] pulses 3 times during an active frame → exactly one further frame for requester 1.
- Snapshot: frame_data[0] changes after the grant → the transmitted bytes match the value present in the capture cycle.
- Watchdog: wr_ack withheld with TIMEOUT_CYCLES=100 → wren falls, and frame_done plus frame_error pulse 100 cycles after SEND entry.
- Reset mid-frame: reset_n low after byte 10 → outputs return to reset values, pending clears, and no frame_done is issued.

Source files
------------

// File: rtl/lighthouse_sched_pkg.sv
// Shared types and constants for the lighthouse frame scheduler.
package lighthouse_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEND     = 3'd1,
    S_WAIT_REQ = 3'd2,
    S_WAIT_END = 3'd3,
    S_GAP      = 3'd4
  } state_t;

  localparam int FRAME_BITS = 256;
  localparam int CNT_W      = 16;
  localparam int ID_W       = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last grant.
module rr_arbiter
  import lighthouse_sched_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_idx,
  output logic            valid
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  always_comb begin
    logic [IDX_W-1:0] cand;
    gnt     = '0;
    gnt_idx = last;
    valid   = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IDX_W'((int'(last) + i) % N);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/lighthouse_frame_scheduler.sv
// Arbitrates 256-bit sensor frames from several sources onto one byte-wide
// SPI master, with end-of-frame detection, inter-frame gap and watchdog.
module lighthouse_frame_scheduler
  import lighthouse_sched_pkg::*;
#(
  parameter int NUMBER_OF_REQUESTERS = 4,
  parameter int FRAME_BYTES          = 32,
  parameter int GAP_CYCLES           = 1024,
  parameter int TIMEOUT_CYCLES       = 65535
) (
  input  logic                                       clock,
  input  logic                                       reset_n,
  input  logic [NUMBER_OF_REQUESTERS-1:0]            req,
  input  logic [NUMBER_OF_REQUESTERS*FRAME_BITS-1:0] frame_data,
  output logic [NUMBER_OF_REQUESTERS-1:0]            grant,
  output logic [ID_W-1:0]                            grant_id,
  output logic                                       busy,
  output logic                                       frame_done,
  output logic                                       frame_error,
  output logic [7:0]                                 data_byte,
  output logic                                       wren,
  input  logic                                       wr_ack,
  input  logic                                       di_req,
  input  logic                                       ss_n
);

  localparam int BCNT_W = $clog2(FRAME_BYTES + 1);
  localparam logic [CNT_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 65535) ? {CNT_W{1'b1}} : CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] WD_LIMIT =
    (TIMEOUT_CYCLES > 65535) ? {CNT_W{1'b1}} : CNT_W'(TIMEOUT_CYCLES);
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(FRAME_BYTES - 1);
  localparam state_t END_STATE = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - CNT_W'(1);
  endfunction

  state_t                          state;
  logic [NUMBER_OF_REQUESTERS-1:0] pending;
  logic [NUMBER_OF_REQUESTERS-1:0] arb_gnt;
  logic [ID_W-1:0]                 arb_idx;
  logic                            arb_valid;
  logic                            capture;
  logic                            ss_n_p1;
  logic                            ss_rise;
  logic                            wd_hit;
  logic [CNT_W-1:0]                wd_cnt;
  logic [CNT_W-1:0]                wd_inc;
  logic [CNT_W-1:0]                gap_cnt;
  logic [BCNT_W-1:0]               byte_cnt;
  logic [FRAME_BITS-1:0]           sel_frame;
  logic [FRAME_BITS-1:0]           buffer;

  rr_arbiter #(.N(NUMBER_OF_REQUESTERS)) u_arb (
    .req     (pending),
    .last    (grant_id),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .valid   (arb_valid)
  );

  assign capture = (state == S_IDLE) && arb_valid;
  assign ss_rise = !ss_n_p1 && ss_n;
  assign wd_inc  = sat_inc(wd_cnt);
  assign wd_hit  = (wd_inc >= WD_LIMIT);
  assign busy    = (state != S_IDLE);

  // One-hot grant doubles as the select for the winner's frame.
  always_comb begin
    sel_frame = '0;
    for (int k = 0; k < NUMBER_OF_REQUESTERS; k++)
      sel_frame = sel_frame |
        ({FRAME_BITS{arb_gnt[k]}} & frame_data[k*FRAME_BITS +: FRAME_BITS]);
  end

  // A new request in the grant cycle must survive the clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      pending <= '0;
    else
      pending <= (pending & ~(capture ? arb_gnt : '0)) | req;
  end

  // Frame snapshot; byte 0 always sits in the low byte.
  always_ff @(posedge clock) begin
    if (capture)
      buffer <= sel_frame;
    else if (state == S_SEND && wr_ack)
      buffer <= buffer >> 8;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      grant       <= '0;
      grant_id    <= ID_W'(NUMBER_OF_REQUESTERS - 1);
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      data_byte   <= '0;
      wren        <= 1'b0;
      byte_cnt    <= '0;
      gap_cnt     <= '0;
      wd_cnt      <= '0;
      ss_n_p1     <= 1'b1;
    end else begin
      grant       <= '0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      ss_n_p1     <= ss_n;
      case (state)
        S_IDLE: begin
          if (arb_valid) begin
            grant     <= arb_gnt;
            grant_id  <= arb_idx;
            data_byte <= sel_frame[7:0];
            wren      <= 1'b1;
            byte_cnt  <= '0;
            wd_cnt    <= '0;
            state     <= S_SEND;
          end
        end
        S_SEND: begin
          if (wr_ack) begin
            wren     <= 1'b0;
            byte_cnt <= byte_cnt + BCNT_W'(1);
            wd_cnt   <= '0;
            state    <= (byte_cnt == LAST_BYTE) ? S_WAIT_END : S_WAIT_REQ;
          end else if (wd_hit) begin
            wren        <= 1'b0;
            frame_done  <= 1'b1;
            frame_error <= 1'b1;
            gap_cnt     <= GAP_LOAD;
            state       <= END_STATE;
          end else begin
            wd_cnt <= wd_inc;
          end
        end
        S_WAIT_REQ: begin
          if (di_req) begin
            data_byte <= buffer[7:0];
            wren      <= 1'b1;
            wd_cnt    <= '0;
            state     <= S_SEND;
          end else if (wd_hit) begin
            wren        <= 1'b0;
            frame_done  <= 1'b1;
            frame_error <= 1'b1;
            gap_cnt     <= GAP_LOAD;
            state       <= END_STATE;
          end else begin
            wd_cnt <= wd_inc;
          end
        end
        S_WAIT_END: begin
          if (ss_rise) begin
            frame_done <= 1'b1;
            gap_cnt    <= GAP_LOAD;
            state      <= END_STATE;
          end else if (wd_hit) begin
            wren        <= 1'b0;
            frame_done  <= 1'b1;
            frame_error <= 1'b1;
            gap_cnt     <= GAP_LOAD;
            state       <= END_STATE;
          end else begin
            wd_cnt <= wd_inc;
          end
        end
        S_GAP: begin
          if (gap_cnt <= CNT_W'(1))
            state <= S_IDLE;
          else
            gap_cnt <= sat_dec(gap_cnt);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lighthouse_frame_scheduler.sv
// Directed bench for lighthouse_frame_scheduler with a byte scoreboard.
module tb_lighthouse_frame_scheduler;

  localparam int N   = 4;
  localparam int FB  = 32;
  localparam int GAP = 1024;
  localparam int TMO = 100;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [N*256-1:0] frame_data;
  logic [N-1:0]   grant;
  logic [3:0]     grant_id;
  logic           busy, frame_done, frame_error;
  logic [7:0]     data_byte;
  logic           wren, wr_ack, di_req, ss_n;

  always #5 clock = ~clock;

  lighthouse_frame_scheduler #(
    .NUMBER_OF_REQUESTERS(N),
    .FRAME_BYTES(FB),
    .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .frame_data(frame_data),
    .grant(grant), .grant_id(grant_id), .busy(busy), .frame_done(frame_done),
    .frame_error(frame_error), .data_byte(data_byte), .wren(wren),
    .wr_ack(wr_ack), .di_req(di_req), .ss_n(ss_n)
  );

  int vectors = 0;
  int miscompares = 0;
  int gcnt [N];
  int multi = 0;
  int fd_cnt = 0;
  int fe_cnt = 0;
  logic [7:0]   byte_q [$];
  logic [255:0] fdm [N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    for (int k = 0; k < N; k++) if (grant[k] === 1'b1) gcnt[k]++;
    if ($countones(grant) > 1) multi++;
    if (frame_done === 1'b1) fd_cnt++;
    if (frame_error === 1'b1) fe_cnt++;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic set_frame(input int k, input logic [255:0] v);
    fdm[k] = v;
    frame_data[k*256 +: 256] = v;
  endtask

  task automatic push_frame(input int k, input int nb);
    for (int i = 0; i < nb; i++) byte_q.push_back(fdm[k][8*i +: 8]);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      n++;
      step();
    end
  endtask

  // Plays the SPI master: acks each byte at once, raises di_req 3 cycles later.
  task automatic serve_frame(input int id, input int nbytes,
                             input logic [N-1:0] side_req, input bit scramble);
    int n;
    logic [7:0] exp_b;
    logic [N-1:0] eg;
    n = 0;
    while (wren !== 1'b1 && n < 100) begin step(); n++; end
    check("grant_wren", 64'(wren), 64'(1));
    eg = '0;
    eg[id] = 1'b1;
    check("grant_onehot", 64'(grant), 64'(eg));
    check("grant_id", 64'(grant_id), 64'(id));
    ss_n = 1'b0;
    if (scramble) frame_data[id*256 +: 256] = ~fdm[id];
    for (int b = 0; b < nbytes; b++) begin
      n = 0;
      while (wren !== 1'b1 && n < 20) begin step(); n++; end
      check("byte_wren", 64'(wren), 64'(1));
      exp_b = 'x;
      if (byte_q.size() > 0) exp_b = byte_q.pop_front();
      check("byte", 64'(data_byte), 64'(exp_b));
      if (b == 2 || b == 9 || b == 17) req = side_req;
      wr_ack = 1'b1;
      step();
      wr_ack = 1'b0;
      req = '0;
      check("wren_drop", 64'(wren), 64'(0));
      if (b < nbytes - 1) begin
        step();
        step();
        di_req = 1'b1;
        step();
        di_req = 1'b0;
      end
    end
    if (nbytes == FB) begin
      step();
      step();
      ss_n = 1'b1;
      step();
      check("frame_done", 64'(frame_done), 64'(1));
      check("frame_error_clear", 64'(frame_error), 64'(0));
      wait_idle(n);
      check("gap_len", 64'(n), 64'(GAP));
    end
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, g1, g2, fd0, gsum;
    logic [255:0] v;
    reset_n = 1'b0;
    req = '0;
    frame_data = '0;
    wr_ack = 1'b0;
    di_req = 1'b0;
    ss_n = 1'b1;
    for (int k = 0; k < N; k++) begin gcnt[k] = 0; fdm[k] = '0; end
    repeat (5) step();

    check("rst_grant", 64'(grant), 64'(0));
    check("rst_grant_id", 64'(grant_id), 64'(N - 1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_frame_done", 64'(frame_done), 64'(0));
    check("rst_frame_error", 64'(frame_error), 64'(0));
    check("rst_data_byte", 64'(data_byte), 64'(0));
    check("rst_wren", 64'(wren), 64'(0));
    reset_n = 1'b1;
    step();
    step();

    // Contention: all four at once, served 0..3
    for (int k = 0; k < N; k++) set_frame(k, rand256());
    for (int k = 0; k < N; k++) push_frame(k, FB);
    req = '1;
    step();
    req = '0;
    for (int k = 0; k < N; k++) serve_frame(k, FB, '0, 1'b0);
    for (int k = 0; k < N; k++) check("contention_grants", 64'(gcnt[k]), 64'(1));

    // Single request, byte k = k
    for (int i = 0; i < 32; i++) v[8*i +: 8] = 8'(i);
    set_frame(2, v);
    push_frame(2, FB);
    g2 = gcnt[2];
    req = 4'b0100;
    step();
    req = '0;
    n = 0;
    while (wren !== 1'b1 && n < 20) begin step(); n++; end
    check("grant_latency", 64'(n), 64'(1));
    serve_frame(2, FB, '0, 1'b0);
    check("single_grant_count", 64'(gcnt[2] - g2), 64'(1));

    // Coalescing: three req[1] pulses during frame 3
    set_frame(3, rand256());
    set_frame(1, rand256());
    push_frame(3, FB);
    push_frame(1, FB);
    g1 = gcnt[1];
    req = 4'b1000;
    step();
    req = '0;
    serve_frame(3, FB, 4'b0010, 1'b0);
    serve_frame(1, FB, '0, 1'b0);
    repeat (50) step();
    check("coalesce_grants", 64'(gcnt[1] - g1), 64'(1));
    check("coalesce_idle", 64'(busy), 64'(0));

    // Snapshot: source changes its frame right after the grant
    set_frame(0, rand256());
    push_frame(0, FB);
    req = 4'b0001;
    step();
    req = '0;
    serve_frame(0, FB, '0, 1'b1);

    // Watchdog: wr_ack withheld
    set_frame(1, rand256());
    frame_data[1*256 +: 256] = fdm[1];
    req = 4'b0010;
    step();
    req = '0;
    n = 0;
    while (wren !== 1'b1 && n < 20) begin step(); n++; end
    check("wd_grant", 64'(grant), 64'(4'b0010));
    check("wd_byte0", 64'(data_byte), 64'(fdm[1][7:0]));
    n = 0;
    while (frame_done !== 1'b1 && n < 300) begin step(); n++; end
    check("wd_latency", 64'(n), 64'(TMO));
    check("wd_error", 64'(frame_error), 64'(1));
    check("wd_wren", 64'(wren), 64'(0));
    wait_idle(n);
    check("wd_gap", 64'(n), 64'(GAP));

    // Reset mid-frame after byte 10, with requester 3 left pending
    set_frame(2, rand256());
    push_frame(2, 11);
    req = 4'b1100;
    step();
    req = '0;
    serve_frame(2, 11, '0, 1'b0);
    fd0 = fd_cnt;
    reset_n = 1'b0;
    ss_n = 1'b1;
    #1;
    check("mid_rst_wren", 64'(wren), 64'(0));
    check("mid_rst_grant_id", 64'(grant_id), 64'(N - 1));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_data_byte", 64'(data_byte), 64'(0));
    check("mid_rst_grant", 64'(grant), 64'(0));
    repeat (3) step();
    reset_n = 1'b1;
    gsum = 0;
    for (int k = 0; k < N; k++) gsum += gcnt[k];
    repeat (100) step();
    n = 0;
    for (int k = 0; k < N; k++) n += gcnt[k];
    check("mid_rst_no_done", 64'(fd_cnt - fd0), 64'(0));
    check("mid_rst_pending_cleared", 64'(n - gsum), 64'(0));
    check("mid_rst_idle", 64'(busy), 64'(0));

    check("queue_empty", 64'(byte_q.size()), 64'(0));
    check("multi_grant", 64'(multi), 64'(0));
    check("error_pulses", 64'(fe_cnt), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
